uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Synthesizable 8N1 UART receiver with a small elastic FIFO.
- Consumes the SoC `uart_tx` serial line and presents received bytes on a valid/ready stream.
- Used by the bench-side capture logic and FPGA debug harness for printf output and end-of-test strings.
- Replaces the behavioural receiver model with cycle-exact, clocked RTL.

Parameters:
- CLKS_PER_BIT, 32, clk cycles per UART bit. 32 gives 781250 baud at 25 MHz. Legal range is 4 or more.
- FIFO_DEPTH, 8, number of byte entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_i  in  1  asynchronous serial input, idle high.
- data_o  out  8  FIFO head byte. Valid only when valid_o=1.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head. A pop occurs when valid_o && ready_i.
- count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low.
- overflow_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy_o  out  1  receiver FSM is not in IDLE.

Behaviour:

Reset:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- On reset, all outputs are 0: data_o=0, valid_o=0, count_o=0, frame_err_o=0, overflow_o=0, busy_o=0.
- The two synchroniser flops reset to 1. The FSM resets to IDLE, the bit counter and shift register to 0, and the FIFO pointers to 0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. No partial byte is ever pushed.

Input sync:
- rx_i passes through a 2-flop synchroniser. All timing below refers to the synchronised signal rxs.

FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - Start edge = rxs==0 while the previous rxs==1. Let t be the cycle the edge is detected.
  - On the edge, go to START and clear the cycle counter.
- START:
  - Sample rxs at t + CLKS_PER_BIT/2 (integer division).
  - If rxs==1, it is a glitch: return to IDLE with no output.
  - If rxs==0, go to DATA.
- DATA:
  - Sample bit k (k=0..7, LSB first) at t + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - Shift each sample into the shift register. After bit 7, go to STOP.
- STOP:
  - Sample at t + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - If rxs==1, push the byte and go to IDLE. The push occurs in the sample cycle.
  - If rxs==0, pulse frame_err_o in the following cycle, discard the byte, and go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE.
  - Prevents a break condition from being decoded as repeated 0x00 frames.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the nominal stop end.
  - A start edge arriving immediately after the stop bit is therefore detected.

Latency:
- valid_o rises the cycle after the stop-sample cycle, with data_o = the received byte.
- A rx_i edge-to-pin delay of 2 extra cycles from the synchroniser applies throughout.

FIFO:
- First-word-fall-through. data_o is the registered head entry.
- count_o and valid_o update the cycle after a push or pop.
- valid_o = (count_o != 0).
- Push and pop in the same cycle: count is unchanged and both complete.
- Push when full without a concurrent pop: the byte is dropped, overflow_o pulses for 1 cycle the next cycle, and FIFO contents are unchanged.
- Push when full with a concurrent pop: the push is accepted and there is no overflow.
- Pop when empty is ignored.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- count_o saturates at FIFO_DEPTH by construction.

busy_o:
- busy_o = (state != IDLE), registered with the state.

Test Plan:
1. Reset, then drive 0x55 at CLKS_PER_BIT=32 with ready_i=1. Required: valid_o pulses for 1 cycle, data_o=0x55, count_o returns to 0, no error pulses.
2. Send 0xA5, 0x3C, 0xFF back-to-back (stop bit immediately followed by start) with ready_i=0. Required: count_o=3. Then raise ready_i: pops return 0xA5, 0x3C, 0xFF in order, and count_o reaches 0.
3. Hold ready_i=0 and send 10 bytes 0x00..0x09 with FIFO_DEPTH=8. Required: count_o=8, overflow_o pulses exactly twice (bytes 0x08 and 0x09), and draining yields 0x00..0x07.
4. Send a frame 0x42 with the stop bit forced low, then hold rx_i low for 40 bit times, then release. Required: one frame_err_o pulse, no push, busy_o stays 1 until the line goes high, and no further bytes are received.
5. Drive a 5-cycle low glitch on rx_i (shorter than CLKS_PER_BIT/2). Required: FSM returns to IDLE, no push, no frame_err_o.
6. Assert rst_n=0 for one cycle mid-DATA of a frame, with 2 bytes queued. Required: count_o=0 and valid_o=0 the next cycle, and no byte is pushed from the aborted frame.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
//   Used to capture the SoC uart_tx line (printf / end-of-test strings) as a
//   valid/ready byte stream.
//
// Ports
//   clk          system clock, everything on the rising edge
//   rst_n        synchronous active-low reset
//   rx_i         asynchronous serial input, idle high
//   data_o       FIFO head byte (meaningful only while valid_o=1)
//   valid_o      FIFO non-empty
//   ready_i      consumer accepts head; a pop is valid_o && ready_i
//   count_o      current FIFO occupancy
//   frame_err_o  one-cycle pulse after a stop bit was sampled low
//   overflow_o   one-cycle pulse after a good byte was dropped (FIFO full)
//   busy_o       receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx_i,
    output logic [7:0]                        data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic                              frame_err_o,
    output logic                              overflow_o,
    output logic                              busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Input synchroniser plus one extra flop for start-edge detection.
    // All three reset to the idle line level so reset never fakes an edge.
    logic sync1_q, sync2_q, rxs_prev_q;
    logic rxs;

    assign rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            rxs_prev_q <= sync2_q;
        end
    end

    // Receiver FSM
    state_t          state_q;
    logic [TW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            frame_err_q;
    logic            busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs && rxs_prev_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};  // LSB arrives first
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit of slack for a
                    // start edge that directly follows the stop bit.
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= WAIT_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // A held-low (break) line must go high before a new frame.
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The push happens in the stop-sample cycle itself.
    logic push;
    assign push = (state_q == STOP) && (cnt_q == BIT_M1) && rxs;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          full, pop, wr_en;

    assign full  = (count_q == FULL_CNT);
    assign pop   = valid_o && ready_i;
    // A concurrent pop frees a slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= push && full && !pop;
        end
    end

    // Storage needs no reset: data_o is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign valid_o     = (count_q != '0);
    assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o     = count_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Bench for uart_rx_fifo: directed scenarios plus randomized frames, with a
//   line-level reference model that decodes frames from sample offsets
//   relative to the detected start edge and keeps the FIFO as a queue.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int C  = 32;
    localparam int D  = 8;
    localparam int H  = C / 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    logic          frame_err_o;
    logic          overflow_o;
    logic          busy_o;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .frame_err_o(frame_err_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 inside a frame, 2 waiting for line high
    int         m_cyc = 0;
    int         m_t = 0;
    int         m_off;
    int         m_phase = 0;
    bit         m_s1 = 1, m_s2 = 1, m_prev = 1, m_rxs;
    bit         m_push, m_pop, m_ovf, m_ferr;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_q[$];
    bit         started = 0;
    int         e_count = 0;
    bit         e_valid = 0, e_ferr = 0, e_ovf = 0, e_busy = 0;
    logic [7:0] e_data = 8'h00;

    always @(posedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_s1 = 1; m_s2 = 1; m_prev = 1;
            m_phase = 0;
            m_q.delete();
            e_ferr = 0; e_ovf = 0; e_busy = 0;
            started = 1;
        end else begin
            m_rxs  = m_s2;
            m_push = 0;
            m_ferr = 0;
            case (m_phase)
                0: if (!m_rxs && m_prev) begin
                    m_phase = 1;
                    m_t = m_cyc;
                end
                1: begin
                    m_off = m_cyc - m_t;
                    if (m_off == H) begin
                        if (m_rxs) m_phase = 0;
                    end else if (m_off == H + 9 * C) begin
                        if (m_rxs) begin
                            m_push = 1;
                            m_phase = 0;
                        end else begin
                            m_ferr = 1;
                            m_phase = 2;
                        end
                    end else if (m_off > H && ((m_off - H) % C) == 0) begin
                        m_byte[(m_off - H) / C - 1] = m_rxs;
                    end
                end
                default: if (m_rxs) m_phase = 0;
            endcase
            m_pop = (m_q.size() != 0) && ready_i;
            m_ovf = m_push && (m_q.size() == D) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && !m_ovf) m_q.push_back(m_byte);
            e_ferr = m_ferr;
            e_ovf  = m_ovf;
            e_busy = (m_phase != 0);
            m_prev = m_rxs;
            m_s2   = m_s1;
            m_s1   = rx_i;
        end
        e_count = m_q.size();
        e_valid = (m_q.size() != 0);
        e_data  = (m_q.size() != 0) ? m_q[0] : 8'h00;
    end

    // Bench bookkeeping, all owned by the stimulus process
    int         checks = 0;
    int         errors = 0;
    logic [7:0] log_q[$];
    int         ferr_cnt = 0, ovf_cnt = 0, vld_cnt = 0;
    bit         rnd_ready = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int log_at(input int idx);
        return (idx < log_q.size()) ? int'(log_q[idx]) : -1;
    endfunction

    // One clock step: log the pop about to happen, then compare the DUT
    // outputs against the model #1 after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            if (valid_o && ready_i) log_q.push_back(data_o);
            @(posedge clk);
            #1;
            if (frame_err_o) ferr_cnt++;
            if (overflow_o) ovf_cnt++;
            if (valid_o) vld_cnt++;
            if (started) begin
                checks++;
                if (int'(count_o) != e_count || valid_o !== e_valid ||
                    (e_valid && data_o !== e_data) || frame_err_o !== e_ferr ||
                    overflow_o !== e_ovf || busy_o !== e_busy) begin
                    errors++;
                    $display("FAIL cycle %0d outputs: count %0d want %0d, valid %b want %b, data %02h want %02h, ferr %b want %b, ovf %b want %b, busy %b want %b",
                             m_cyc, count_o, e_count, valid_o, e_valid, data_o, e_data,
                             frame_err_o, e_ferr, overflow_o, e_ovf, busy_o, e_busy);
                end
            end
            if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        tick(C);
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            tick(C);
        end
        rx_i = stop_bit;
        tick(C);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_log, s_ferr, s_ovf, s_vld;
        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        tick(3);
        chk("reset data_o", data_o, 0);
        chk("reset valid_o", valid_o, 0);
        chk("reset count_o", count_o, 0);
        chk("reset frame_err_o", frame_err_o, 0);
        chk("reset overflow_o", overflow_o, 0);
        chk("reset busy_o", busy_o, 0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte, consumer always ready
        ready_i = 1'b1;
        s_log = log_q.size(); s_ferr = ferr_cnt; s_ovf = ovf_cnt; s_vld = vld_cnt;
        send_byte(8'h55, 1'b1);
        tick(10);
        chk("t1 pops", log_q.size() - s_log, 1);
        chk("t1 data", log_at(s_log), 8'h55);
        chk("t1 valid cycles", vld_cnt - s_vld, 1);
        chk("t1 count", count_o, 0);
        chk("t1 errors pulses", (ferr_cnt - s_ferr) + (ovf_cnt - s_ovf), 0);

        // 2: three back-to-back frames queued, then drained
        ready_i = 1'b0;
        s_log = log_q.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(4);
        chk("t2 count", count_o, 3);
        ready_i = 1'b1;
        tick(8);
        ready_i = 1'b0;
        chk("t2 pop0", log_at(s_log), 8'hA5);
        chk("t2 pop1", log_at(s_log + 1), 8'h3C);
        chk("t2 pop2", log_at(s_log + 2), 8'hFF);
        chk("t2 count drained", count_o, 0);

        // 3: overflow with ten bytes into an eight-entry FIFO
        s_log = log_q.size(); s_ovf = ovf_cnt;
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1);
        tick(4);
        chk("t3 count full", count_o, D);
        chk("t3 overflow pulses", ovf_cnt - s_ovf, 2);
        ready_i = 1'b1;
        tick(14);
        ready_i = 1'b0;
        chk("t3 pops", log_q.size() - s_log, 8);
        for (int i = 0; i < 8; i++) chk("t3 drain order", log_at(s_log + i), i);

        // 4: bad stop bit followed by a long break
        s_ferr = ferr_cnt; s_log = log_q.size();
        send_byte(8'h42, 1'b0);
        tick(40 * C);
        chk("t4 busy in break", busy_o, 1);
        chk("t4 frame_err pulses", ferr_cnt - s_ferr, 1);
        chk("t4 count", count_o, 0);
        rx_i = 1'b1;
        tick(C);
        chk("t4 busy after release", busy_o, 0);
        chk("t4 frame_err pulses after", ferr_cnt - s_ferr, 1);
        chk("t4 no bytes", count_o, 0);

        // 5: short low glitch
        s_ferr = ferr_cnt;
        rx_i = 1'b0;
        tick(5);
        rx_i = 1'b1;
        tick(2 * C);
        chk("t5 count", count_o, 0);
        chk("t5 frame_err", ferr_cnt - s_ferr, 0);
        chk("t5 busy", busy_o, 0);

        // 6: reset in the middle of a data phase with two bytes queued
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(2);
        chk("t6 queued", count_o, 2);
        rx_i = 1'b0;
        tick(C);
        rx_i = 1'b1;
        tick(C);
        rx_i = 1'b0;
        tick(C + 7);
        rst_n = 1'b0;
        tick(1);
        chk("t6 count after reset", count_o, 0);
        chk("t6 valid after reset", valid_o, 0);
        rst_n = 1'b1;
        rx_i  = 1'b1;
        tick(12 * C);
        chk("t6 no push", count_o, 0);
        chk("t6 idle", busy_o, 0);

        // Randomized traffic: good, bad-stop and glitch frames, random ready
        rnd_ready = 1;
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                rx_i = 1'b0;
                tick($urandom_range(1, H - 1));
                rx_i = 1'b1;
                tick(H + 4);
            end else begin
                send_byte(8'($urandom), (kind != 1));
                if (kind == 1) tick($urandom_range(0, 3 * C));
                rx_i = 1'b1;
                if ($urandom_range(0, 2) != 0) tick($urandom_range(1, 2 * C));
            end
        end
        rnd_ready = 0;
        rx_i = 1'b1;
        ready_i = 1'b1;
        tick(12 * C);
        chk("random drained", count_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
